// File: rtl/reg_wb_pkg.sv
// Shared types and widths for the register-bank writeback path.
package reg_wb_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // Round-robin priority between the two result sources
  typedef enum logic {
    RR_ALU = 1'b0,
    RR_LD  = 1'b1
  } rr_sel_t;

endpackage

// File: rtl/reg_wb_fifo.sv
// DEPTH-entry writeback FIFO; entry contents and validity are exported
// for the forwarding lookup only when REG_WB_FORWARD_EN is defined.
module reg_wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count
`ifdef REG_WB_FORWARD_EN
  ,
  output wb_entry_t [DEPTH-1:0]    entries,
  output logic [DEPTH-1:0]         entry_valid,
  output logic [$clog2(DEPTH)-1:0] rd_ptr_q
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // Storage carries no reset; occupancy is defined solely by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

`ifdef REG_WB_FORWARD_EN
  always_comb begin
    entry_valid = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      // Slot age relative to the head, wrapping modulo DEPTH
      entry_valid[k] = ({1'b0, PTR_W'(k) - rd_ptr} < count);
    end
  end

  assign entries  = mem;
  assign rd_ptr_q = rd_ptr;
`endif

endmodule

// File: rtl/reg_writeback_unit.sv
// Writeback master for the 64x32 register bank: arbitrates ALU/load results into a FIFO
// and issues one write per cycle. Forwarding lookup is built only with REG_WB_FORWARD_EN.
module reg_writeback_unit
  import reg_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              Slow_Clock,
  input  logic              Reset,
  input  logic              Alu_Valid,
  output logic              Alu_Ready,
  input  logic [ADDR_W-1:0] Alu_Reg,
  input  logic [DATA_W-1:0] Alu_Data,
  input  logic              Ld_Valid,
  output logic              Ld_Ready,
  input  logic [ADDR_W-1:0] Ld_Reg,
  input  logic [DATA_W-1:0] Ld_Data,
  input  logic              Stall,
  output logic              Reg_Write,
  output logic [ADDR_W-1:0] Reg_WR,
  output logic [DATA_W-1:0] Write_Data,
  input  logic [ADDR_W-1:0] Query_Reg,
  output logic              Query_Hit,
  output logic [DATA_W-1:0] Query_Data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rr_sel_t          rr_sel;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             alu_acc;
  logic             ld_acc;
  logic             contended;
  logic             push;
  logic             pop;
  wb_entry_t        push_entry;
  wb_entry_t        head;

`ifdef REG_WB_FORWARD_EN
  wb_entry_t [DEPTH-1:0] fifo_entries;
  logic [DEPTH-1:0]      fifo_valid;
  logic [PTR_W-1:0]      fifo_rd_ptr;
`endif

  assign fifo_full = (fifo_count == CNT_W'(DEPTH));

  // A source is refused only when the FIFO is full or it loses a contended cycle
  assign Alu_Ready = !Reset && !fifo_full && (!Ld_Valid || (rr_sel == RR_ALU));
  assign Ld_Ready  = !Reset && !fifo_full && (!Alu_Valid || (rr_sel == RR_LD));

  assign alu_acc   = Alu_Valid && Alu_Ready;
  assign ld_acc    = Ld_Valid && Ld_Ready;
  assign contended = Alu_Valid && Ld_Valid;

  always_comb begin
    push_entry = '0;
    if (alu_acc) begin
      push_entry.addr = Alu_Reg;
      push_entry.data = Alu_Data;
    end else begin
      push_entry.addr = Ld_Reg;
      push_entry.data = Ld_Data;
    end
  end

  // Writes to register 0 complete the handshake but never reach the bank
  assign push = (alu_acc || ld_acc) && (push_entry.addr != REG_ZERO);
  assign pop  = (fifo_count != '0) && !Stall;

  reg_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (Slow_Clock),
    .reset      (Reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count)
`ifdef REG_WB_FORWARD_EN
    ,
    .entries    (fifo_entries),
    .entry_valid(fifo_valid),
    .rd_ptr_q   (fifo_rd_ptr)
`endif
  );

  always_ff @(posedge Slow_Clock) begin
    if (Reset) begin
      Reg_Write  <= 1'b0;
      Reg_WR     <= '0;
      Write_Data <= '0;
      rr_sel     <= RR_ALU;
    end else begin
      Reg_Write <= pop;
      if (pop) begin
        Reg_WR     <= head.addr;
        Write_Data <= head.data;
      end
      if (contended && (alu_acc || ld_acc)) begin
        rr_sel <= (rr_sel == RR_ALU) ? RR_LD : RR_ALU;
      end
    end
  end

`ifdef REG_WB_FORWARD_EN
  logic [PTR_W-1:0] q_idx;

  // Scan oldest to youngest so the last match (tail side) wins over older data
  always_comb begin
    Query_Hit  = 1'b0;
    Query_Data = '0;
    q_idx      = '0;
    if (Query_Reg != REG_ZERO) begin
      if (Reg_Write && (Reg_WR == Query_Reg)) begin
        Query_Hit  = 1'b1;
        Query_Data = Write_Data;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_idx = fifo_rd_ptr + PTR_W'(i);
        if (fifo_valid[q_idx] && (fifo_entries[q_idx].addr == Query_Reg)) begin
          Query_Hit  = 1'b1;
          Query_Data = fifo_entries[q_idx].data;
        end
      end
    end
  end
`else
  logic unused_query_reg;

  assign unused_query_reg = ^Query_Reg;
  assign Query_Hit        = 1'b0;
  assign Query_Data       = '0;
`endif

endmodule
